// File: rtl/lookup3_pkg.sv
// Shared definitions for the lookup3 (Bob Jenkins) hash engine: FSM states,
// golden constant, per-line rotate tables and the 32-bit rotate helper.
package lookup3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MIX,
    FINAL,
    DONE
  } state_t;

  localparam logic [31:0] LOOKUP3_GOLDEN = 32'hDEADBEEF;

  localparam logic [0:5][4:0] MIX_ROT = {5'd4, 5'd6, 5'd8, 5'd16, 5'd19, 5'd4};
  localparam logic [0:6][4:0] FIN_ROT = {5'd14, 5'd11, 5'd25, 5'd16, 5'd4, 5'd14, 5'd24};

  function automatic logic [31:0] rot32(input logic [31:0] x, input logic [4:0] r);
    return (x << r) | (x >> (6'd32 - {1'b0, r}));
  endfunction

endpackage

// File: rtl/lookup3_step.sv
// One lookup3 round line per evaluation: a mix() line (step 0..5) or a
// final() line (step 0..6), selected by fin. Purely combinational.
module lookup3_step
  import lookup3_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [2:0]  step,
  input  logic        fin,
  output logic [31:0] na,
  output logic [31:0] nb,
  output logic [31:0] nc
);

  logic [1:0] lane;
  logic [4:0] r;

  // The three register roles rotate every line, so the lane is step mod 3.
  always_comb begin
    case (step)
      3'd0, 3'd3, 3'd6: lane = 2'd0;
      3'd1, 3'd4:       lane = 2'd1;
      default:          lane = 2'd2;
    endcase
  end

  always_comb begin
    na = a;
    nb = b;
    nc = c;
    r  = fin ? FIN_ROT[step] : MIX_ROT[step];
    if (fin) begin
      case (lane)
        2'd0:    nc = (c ^ b) - rot32(b, r);
        2'd1:    na = (a ^ c) - rot32(c, r);
        default: nb = (b ^ a) - rot32(a, r);
      endcase
    end else begin
      case (lane)
        2'd0: begin
          na = (a - c) ^ rot32(c, r);
          nc = c + b;
        end
        2'd1: begin
          nb = (b - a) ^ rot32(a, r);
          na = a + c;
        end
        default: begin
          nc = (c - b) ^ rot32(b, r);
          nb = b + a;
        end
      endcase
    end
  end

endmodule

// File: rtl/lookup3_hash.sv
// Streaming lookup3 hashlittle/hashbig engine, one mix/final line per cycle.
// Define LOOKUP3_HASH2_EN to add the hash_b output (hashlittle2/hashbig2, pb=0).
module lookup3_hash
  import lookup3_pkg::*;
#(
  parameter int LEN_W      = 32,
  parameter bit BIG_ENDIAN = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_init,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [31:0]      din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      hash_c
`ifdef LOOKUP3_HASH2_EN
  ,
  output logic [31:0]      hash_b
`endif
);

  state_t           state, state_n;
  logic [31:0]      a, b, c, a_n, b_n, c_n;
  logic [31:0]      sa, sb, sc;
  logic [LEN_W-1:0] rem, rem_n;
  logic [1:0]       widx, widx_n;
  logic [2:0]       step, step_n;
  logic             run, cap;
  logic [31:0]      init_v, word;
  logic [3:0]       wbytes;
  logic             last_blk, last_word;

  // Keeps the valid tail bytes of the final key word; byte order follows din packing.
  function automatic logic [31:0] tail_mask(input logic [2:0] n);
    logic [31:0] m;
    case (n)
      3'd1:    m = 32'h0000_00FF;
      3'd2:    m = 32'h0000_FFFF;
      3'd3:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    if (BIG_ENDIAN) m = {m[7:0], m[15:8], m[23:16], m[31:24]};
    return m;
  endfunction

  assign cmd_ready = run && (state == IDLE);
  assign din_ready = (state == LOAD) && (rem != '0);
  assign out_valid = (state == DONE);

  assign init_v    = LOOKUP3_GOLDEN + 32'(cmd_len) + cmd_init;
  assign last_blk  = (rem <= LEN_W'(12));
  assign wbytes    = rem[3:0] - {widx, 2'b00};
  assign last_word = last_blk && (wbytes <= 4'd4);
  assign word      = last_word ? (din & tail_mask(wbytes[2:0])) : din;

  lookup3_step u_step (
    .a    (a),
    .b    (b),
    .c    (c),
    .step (step),
    .fin  (state == FINAL),
    .na   (sa),
    .nb   (sb),
    .nc   (sc)
  );

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    c_n     = c;
    rem_n   = rem;
    widx_n  = widx;
    step_n  = step;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_n     = init_v;
          b_n     = init_v;
          c_n     = init_v;
          rem_n   = cmd_len;
          widx_n  = 2'd0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (rem == '0) begin
          cap     = 1'b1;
          state_n = DONE;
        end else if (din_valid) begin
          case (widx)
            2'd0:    a_n = a + word;
            2'd1:    b_n = b + word;
            default: c_n = c + word;
          endcase
          step_n = 3'd0;
          if (last_word) begin
            state_n = FINAL;
          end else if (!last_blk && (widx == 2'd2)) begin
            state_n = MIX;
            rem_n   = rem - LEN_W'(12);
            widx_n  = 2'd0;
          end else begin
            widx_n = widx + 2'd1;
          end
        end
      end
      MIX: begin
        a_n    = sa;
        b_n    = sb;
        c_n    = sc;
        step_n = step + 3'd1;
        if (step == 3'd5) state_n = LOAD;
      end
      FINAL: begin
        a_n    = sa;
        b_n    = sb;
        c_n    = sc;
        step_n = step + 3'd1;
        if (step == 3'd6) begin
          cap     = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      rem   <= '0;
      widx  <= '0;
      step  <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      c     <= c_n;
      rem   <= rem_n;
      widx  <= widx_n;
      step  <= step_n;
      run   <= 1'b1;
    end
  end

  // The last final line only rewrites c, so b is already the final b here.
  always_ff @(posedge clk) begin
    if (!res) hash_c <= '0;
    else if (cap) hash_c <= (state == FINAL) ? sc : c;
  end

`ifdef LOOKUP3_HASH2_EN
  always_ff @(posedge clk) begin
    if (!res) hash_b <= '0;
    else if (cap) hash_b <= b;
  end
`endif

endmodule

// File: tb/tb_lookup3_hash.sv
// Table-driven bench for lookup3_hash with a reference hashlittle2 model and
// an expected-result queue; also covers mid-job reset and handshake overlap.
`timescale 1ns/1ps
module tb_lookup3_hash;

  localparam int LEN_W = 32;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0]      cmd_init = '0;
  logic             din_valid = 1'b0;
  logic [31:0]      din = '0;
  logic             out_ready = 1'b0;
  logic             cmd_ready, din_ready, out_valid;
  logic [31:0]      hash_c;
`ifdef LOOKUP3_HASH2_EN
  logic [31:0]      hash_b;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  key [0:63];
  logic [63:0] sb_q [$];

  typedef struct {
    int          len;
    logic [31:0] init;
    logic [31:0] exp_c;
    logic [31:0] exp_b;
    bit          mc;
    bit          mb;
    bit          gaps;
    int          stall;
    bit          overlap;
  } vec_t;

  vec_t  vt  [10];
  string txt [10];

  always #5 clk = ~clk;

  lookup3_hash #(.LEN_W(LEN_W), .BIG_ENDIAN(0)) dut (
    .clk       (clk),
    .res       (res),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_init  (cmd_init),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hash_c    (hash_c)
`ifdef LOOKUP3_HASH2_EN
    ,
    .hash_b    (hash_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] kword(input int base, input int len);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (base + j < len) w[8*j +: 8] = key[base + j];
    return w;
  endfunction

  // Straight transcription of hashlittle2 (pb=0): returns {c, b}.
  function automatic logic [63:0] model(input int len, input logic [31:0] init);
    logic [31:0] a, b, c;
    int n, off;
    a = 32'hDEADBEEF + 32'(len) + init;
    b = a;
    c = a;
    n = len;
    off = 0;
    while (n > 12) begin
      a += kword(off, len); b += kword(off + 4, len); c += kword(off + 8, len);
      a -= c; a ^= rotl(c, 4);  c += b;
      b -= a; b ^= rotl(a, 6);  a += c;
      c -= b; c ^= rotl(b, 8);  b += a;
      a -= c; a ^= rotl(c, 16); c += b;
      b -= a; b ^= rotl(a, 19); a += c;
      c -= b; c ^= rotl(b, 4);  b += a;
      n -= 12;
      off += 12;
    end
    if (n > 0) begin
      a += kword(off, len);
      if (n > 4) b += kword(off + 4, len);
      if (n > 8) c += kword(off + 8, len);
      c ^= b; c -= rotl(b, 14);
      a ^= c; a -= rotl(c, 11);
      b ^= a; b -= rotl(a, 25);
      c ^= b; c -= rotl(b, 16);
      a ^= c; a -= rotl(c, 4);
      b ^= a; b -= rotl(a, 14);
      c ^= b; c -= rotl(b, 24);
    end
    return {c, b};
  endfunction

  // Bytes past the key are junk so the tail mask is exercised.
  task automatic load_key(input string s);
    for (int i = 0; i < 64; i++)
      key[i] = (i < s.len()) ? s[i] : (8'hA5 ^ 8'(i));
  endtask

  task automatic run_job(input int len, input logic [31:0] init, input logic [63:0] exp,
                         input bit gaps, input int stall, input int abort_at,
                         input bit overlap, input string tag);
    int edges, wi, nw, exp_edge;
    bit got;
    logic [63:0] e;
    logic [31:0] held;
    nw = (len + 3) / 4;
    exp_edge = (len == 0) ? 1 : nw + 6 * ((len + 11) / 12 - 1) + 7;
    @(negedge clk);
    check({tag, "/cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_init  = init;
    if (abort_at == 0) sb_q.push_back(exp);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    edges = 0;
    wi = 0;
    got = 1'b0;
    while (!got && edges < 400) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else if (abort_at != 0 && edges == abort_at) break;
      else begin
        if (!din_ready || wi >= nw) begin
          din_valid = 1'b1;
          din = $urandom;
        end else if (gaps && $urandom_range(0, 2) == 0) begin
          din_valid = 1'b0;
          din = $urandom;
        end else begin
          din_valid = 1'b1;
          din = {key[4*wi+3], key[4*wi+2], key[4*wi+1], key[4*wi]};
          wi++;
        end
        @(posedge clk);
        edges++;
      end
    end
    din_valid = 1'b0;
    if (abort_at != 0) return;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s/timeout: no out_valid after %0d edges", tag, edges);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (!gaps) check({tag, "/latency"}, 32'(edges), 32'(exp_edge));
    held = hash_c;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "/stall_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "/stall_hold"}, hash_c, held);
    end
    e = sb_q.pop_front();
    check({tag, "/hash_c"}, hash_c, e[63:32]);
`ifdef LOOKUP3_HASH2_EN
    check({tag, "/hash_b"}, hash_b, e[31:0]);
`endif
    out_ready = 1'b1;
    if (overlap) begin
      cmd_valid = 1'b1;
      cmd_len   = '0;
      cmd_init  = '0;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, "/out_drop"}, {31'd0, out_valid}, 32'd0);
    if (overlap) check({tag, "/overlap_idle"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m, e;
    bit spurious;

    txt[0] = "";
    vt[0] = '{0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0};
    txt[1] = "";
    vt[1] = '{0, 32'hDEADBEEF, 32'hBD5B7DDE, 32'hBD5B7DDE, 0, 0, 0, 0, 0};
    txt[2] = "Four score and seven years ago";
    vt[2] = '{30, 32'h0, 32'h17770551, 32'hCE7226E6, 0, 0, 0, 0, 0};
    txt[3] = "Four score and seven years ago";
    vt[3] = '{30, 32'h1, 32'hCD628161, 32'h0, 0, 1, 0, 0, 1};
    txt[4] = "abcdefghijklmnopqrstuvwx";
    vt[4] = '{24, 32'h9E3779B9, 32'h0, 32'h0, 1, 1, 1, 5, 0};
    txt[5] = "hello, world!";
    vt[5] = '{13, 32'h0, 32'h0, 32'h0, 1, 1, 1, 5, 0};
    txt[6] = "ABCDEFGHIJKL";
    vt[6] = '{12, 32'h7, 32'h0, 32'h0, 1, 1, 0, 0, 0};
    txt[7] = "Z";
    vt[7] = '{1, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0, 0};
    txt[8] = "12345";
    vt[8] = '{5, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 1, 1, 2, 0};
    txt[9] = "The quick brown fox jumps o";
    vt[9] = '{27, 32'hC0FFEE00, 32'h0, 32'h0, 1, 1, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/din_ready", {31'd0, din_ready}, 32'd0);
    check("rst/hash_c", hash_c, 32'd0);
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst/cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      load_key(txt[i]);
      m = model(vt[i].len, vt[i].init);
      e = {vt[i].mc ? m[63:32] : vt[i].exp_c, vt[i].mb ? m[31:0] : vt[i].exp_b};
      run_job(vt[i].len, vt[i].init, e, vt[i].gaps, vt[i].stall, 0, vt[i].overlap,
              $sformatf("v%0d", i));
    end

    // Abort a job while it is mixing its first block.
    load_key(txt[2]);
    run_job(30, 32'h0, 64'h0, 1'b0, 0, 6, 1'b0, "abort");
    check("abort/in_mix", {31'd0, din_ready}, 32'd0);
    res = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort/out_valid", {31'd0, out_valid}, 32'd0);
    check("abort/din_ready", {31'd0, din_ready}, 32'd0);
    check("abort/hash_c", hash_c, 32'd0);
    @(posedge clk);
    #1 res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort/cmd_ready", {31'd0, cmd_ready}, 32'd1);
    spurious = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    check("abort/spurious", {31'd0, spurious}, 32'd0);
    run_job(0, 32'h0, {32'hDEADBEEF, 32'hDEADBEEF}, 1'b0, 0, 0, 1'b0, "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lookup3_hash.md
LOOKUP3_HASH -- requirements
Module: lookup3_hash

Interface
REQ-001 SHALL have parameter LEN_W, default 32: width of the key-length field in bytes, range 4..32.
REQ-002 SHALL have parameter BIG_ENDIAN, default 0: 0 = hashlittle byte packing and tail masks, 1 = hashbig.
REQ-003 SHALL have ports clk (input, 1, clock) and res (input, 1); reset is synchronous and active-low, and the polarity and synchronicity are fixed.
REQ-004 cmd_valid  input  1  request to start a hash.
REQ-005 cmd_ready  output 1  high only in IDLE.
REQ-006 cmd_len  input  LEN_W  key length in bytes.
REQ-007 cmd_init  input  32  initval.
REQ-008 din_valid  input  1  key word valid.
REQ-009 din_ready  output 1  high only in LOAD.
REQ-010 din  input  32  key word: byte i of the word sits at [8i+7:8i] when BIG_ENDIAN=0, at [31-8i:24-8i] when 1.
REQ-011 out_valid  output 1  hash result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 hash_c  output 32  primary hash.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, MIX, FINAL and DONE.
REQ-015 On cmd handshake, a, b and c SHALL each be set to 0xDEADBEEF + zero-extended cmd_len[min(LEN_W,32)-1:0] + cmd_init, all arithmetic mod 2^32.
REQ-016 The remaining-byte count SHALL load from cmd_len on the cmd handshake.
REQ-017 cmd_len = 0 SHALL go to DONE with hash_c = the initial c, with no final step.
REQ-018 LOAD SHALL accept one word per din handshake and add it to a, b, c in turn for word index 0, 1, 2 of the current 12-byte block.
REQ-019 While more than 12 bytes remain, after word 2 the FSM SHALL go to MIX, decrement the remaining count by 12, then return to LOAD.
REQ-020 MIX SHALL take 6 cycles, one lookup3 mix line per cycle; the rotates are 4, 6, 8, 16, 19, 4.
REQ-021 The last block (1..12 bytes, a multiple of 12 included) SHALL accept exactly ceil(rem/4) words, and absent words SHALL contribute 0.
REQ-022 In the last word of the last block, bytes beyond the key length SHALL be masked to 0 before the add: low-order bytes kept for hashlittle (e.g. 0x00FFFFFF for 3 bytes), high-order bytes kept for hashbig (e.g. 0xFFFFFF00).
REQ-023 After the last block the FSM SHALL go to FINAL: 7 cycles, one final line per cycle; the rotates are 14, 11, 25, 16, 4, 14, 24.
REQ-024 DONE SHALL hold out_valid and hash_c stable until out_ready is high, then go to IDLE.
REQ-025 A cmd_valid in the same cycle as the out handshake SHALL be accepted no earlier than the following cycle.
REQ-026 With din_valid held high, out_valid SHALL rise at edge W + 6(B-1) + 7 after the cmd handshake edge, where W = ceil(L/4) and B = ceil(L/12); this gives 1 for L=0.
REQ-027 din_valid stalls SHALL extend LOAD only and SHALL NOT corrupt state.
REQ-028 Words presented outside LOAD SHALL be ignored.

Reset
REQ-029 When res is low at a clk edge, the block SHALL enter IDLE and clear a, b, c, hash_c and counters to 0.
REQ-030 During reset, out_valid and din_ready SHALL be 0 and cmd_ready SHALL be 1 from the first edge after release.
REQ-031 Reset mid-operation SHALL discard the job with no output.

Configuration
REQ-032 The macro is LOOKUP3_HASH2_EN.
REQ-033 With LOOKUP3_HASH2_EN defined, the block SHALL add output hash_b (32), the final b value, valid with out_valid (hashlittle2/hashbig2 with pb=0).
REQ-034 Without LOOKUP3_HASH2_EN, the hash_b port and its register SHALL be absent.
REQ-035 The macro SHALL have no effect on timing.

Structure
REQ-036 Package lookup3_pkg SHALL hold the state enum, LOOKUP3_GOLDEN = 32'hDEADBEEF, the mix and final rotate tables and a rot32 function.
REQ-037 Sub-module lookup3_step SHALL be a combinational round unit: inputs a, b, c, step index and mix/final select; outputs next a, b, c.

Verification
REQ-038 L=0, init=0 -> hash_c=0xDEADBEEF, out_valid at edge 1; with HASH2, hash_b=0xDEADBEEF.
REQ-039 L=0, init=0xDEADBEEF -> hash_c=0xBD5B7DDE.
REQ-040 "Four score and seven years ago", L=30, init=0, BIG_ENDIAN=0 -> hash_c=0x17770551, hash_b=0xCE7226E6, out_valid at edge 27.
REQ-041 Same key, L=30, init=1 -> hash_c=0xCD628161.
REQ-042 L=24 (exact block multiple) and L=13, with random din_valid gaps and out_ready low for 5 cycles -> results match the C model and hash_c is stable while stalled.
REQ-043 Reset asserted during MIX, then an L=0 job -> no spurious out_valid, and 0xDEADBEEF is returned.
